pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Drives next_pc into the fetch-stage PC register and qualifies its output toward instruction fetch.
//   Sequences boot, sequential advance, redirects (exception/eret, backend flush), post-redirect
//   bubbles and halt (WAIT). Sits between the PC register, the fetch unit and the commit/exception logic.
// PARAMETERS
//   ADDR_WIDTH       32            address width (matches ADDR_BUS)
//   INIT_PC          32'hbfc00000  boot address driven while in BOOT
//   BOOT_CYCLES      2             cycles in BOOT before first fetch (>=1)
//   REDIRECT_BUBBLE  1             fetch_valid-low cycles after a redirect (0 = none)
//   CNT_WIDTH        4             width of internal boot/bubble counter
// PORTS
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous reset, active-high
//   pc_in        in   ADDR_WIDTH  current PC (PC register pc_out)
//   next_pc      out  ADDR_WIDTH  value loaded into PC register every cycle
//   fetch_valid  out  1           fetch_pc valid toward fetch unit
//   fetch_pc     out  ADDR_WIDTH  fetch address, = pc_in
//   fetch_ready  in   1           fetch unit accepts fetch_pc (fire = valid & ready)
//   exc_valid    in   1           exception/eret redirect request, 1-cycle pulse
//   exc_pc       in   ADDR_WIDTH  exception/eret target
//   flush_valid  in   1           backend flush (mispredict) redirect, 1-cycle pulse
//   flush_pc     in   ADDR_WIDTH  flush target
//   halt_req     in   1           enter halt after current fetch fires (WAIT)
//   wake         in   1           leave halt, resume at pc_in
//   halted       out  1           1 while in HALT
//   pred_valid   in   1           [PC_PREDICT_EN only] predictor overrides sequential target
//   pred_pc      in   ADDR_WIDTH  [PC_PREDICT_EN only] predicted target
// BEHAVIOUR
//   - States BOOT, RUN, FLUSH, HALT. rst (async, any time, mid-operation included): state=BOOT,
//     cnt=BOOT_CYCLES; outputs then fetch_valid=0, halted=0, next_pc=INIT_PC.
//   - seq_pc = pc_in + 4, modulo 2^ADDR_WIDTH (wraps 32'hfffffffc -> 0). redirect = exc_valid|flush_valid;
//     target = exc_valid ? exc_pc : flush_pc (exception wins when both asserted).
//   - BOOT: fetch_valid=0, next_pc=INIT_PC; cnt decrements; cnt==1 -> RUN. Redirects ignored.
//   - RUN: fetch_valid=1, fetch_pc=pc_in.
//       redirect: next_pc=target, fetch_valid forced 0 this cycle (retraction allowed only here);
//         REDIRECT_BUBBLE==0 -> stay RUN, else -> FLUSH with cnt=REDIRECT_BUBBLE.
//       else fire: next_pc=seq_pc; if halt_req -> HALT.
//       else (valid & !ready): next_pc=pc_in; fetch_pc held stable until fire. halt_req waits for fire.
//   - FLUSH: fetch_valid=0, next_pc=pc_in; cnt decrements; cnt==1 -> RUN. Redirect in FLUSH:
//     next_pc=target, cnt reloaded to REDIRECT_BUBBLE. halt_req ignored.
//   - HALT: fetch_valid=0, halted=1, next_pc=pc_in. redirect -> same handling as in RUN (exits HALT);
//     else wake -> RUN (fetch resumes at pc_in next cycle). redirect and wake together: redirect wins.
//   - Redirect and halt_req in same cycle: redirect wins, halt_req dropped.
//   - Latency: redirect at cycle t -> pc_in=target at t+1 -> fetch_valid=1 at t+1+REDIRECT_BUBBLE.
//   - next_pc, fetch_valid, halted combinational from state, cnt and inputs; state and cnt registered.
// CONFIGURATION
//   PC_PREDICT_EN defined: pred_valid/pred_pc ports present; on fire in RUN with no redirect,
//     next_pc = pred_valid ? pred_pc : seq_pc. Redirects still override prediction.
//   PC_PREDICT_EN undefined: ports absent; sequential target always seq_pc.
// TESTING
//   rst pulse, fetch_ready=1 -> fetch_valid=0 for 2 cycles, then fetch_pc 0xbfc00000, 0xbfc00004, 0xbfc00008.
//   fetch_ready=0 for 3 cycles at pc 0xbfc00010 -> fetch_valid=1, fetch_pc=0xbfc00010 stable; advances to 0xbfc00014 after fire.
//   exc_valid+flush_valid same cycle, exc_pc=0xbfc00380, flush_pc=0x80001000 -> fetch_valid 0 that cycle, 1-cycle bubble, next fetch_pc 0xbfc00380.
//   halt_req at fire of 0x80000020 -> halted=1, fetch_valid=0; wake -> fetch_pc 0x80000024; exc_valid in HALT -> resumes at exc_pc.
//   pc_in 0xfffffffc fire -> next fetch_pc 0x00000000; rst asserted in FLUSH -> BOOT, fetch_valid=0 within same cycle.
//   PC_PREDICT_EN: pred_valid=1, pred_pc=0x80000100 on fire -> next fetch_pc 0x80000100; with flush_valid same cycle -> flush_pc wins.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of pc_sequencer: PC register feedback, fetch handshake, redirects, halt control.
// master = sequencer, slave = surrounding pipeline. Prediction signals exist only with PC_PREDICT_EN.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_in;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fetch_ready;
  logic                  exc_valid;
  logic [ADDR_WIDTH-1:0] exc_pc;
  logic                  flush_valid;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic                  halt_req;
  logic                  wake;
  logic                  halted;
`ifdef PC_PREDICT_EN
  logic                  pred_valid;
  logic [ADDR_WIDTH-1:0] pred_pc;
`endif

  modport master (
    input  pc_in, fetch_ready, exc_valid, exc_pc, flush_valid, flush_pc, halt_req, wake,
`ifdef PC_PREDICT_EN
    input  pred_valid, pred_pc,
`endif
    output next_pc, fetch_valid, fetch_pc, halted
  );

  modport slave (
    output pc_in, fetch_ready, exc_valid, exc_pc, flush_valid, flush_pc, halt_req, wake,
`ifdef PC_PREDICT_EN
    output pred_valid, pred_pc,
`endif
    input  next_pc, fetch_valid, fetch_pc, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: boot, sequential advance, exception/flush redirects with bubbles, WAIT halt.
// Outputs are combinational from state/cnt/inputs. Optional PC_PREDICT_EN adds predictor override on fire.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] INIT_PC         = 32'hbfc00000,
  parameter int                    BOOT_CYCLES     = 2,
  parameter int                    REDIRECT_BUBBLE = 1,
  parameter int                    CNT_WIDTH       = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] BOOT_CNT   = CNT_WIDTH'(BOOT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] BUBBLE_CNT = CNT_WIDTH'(REDIRECT_BUBBLE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [1:0]            state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] seq_target;

  assign redirect = bus.exc_valid | bus.flush_valid;
  assign target   = bus.exc_valid ? bus.exc_pc : bus.flush_pc;
  assign seq_pc   = bus.pc_in + ADDR_WIDTH'(4);

`ifdef PC_PREDICT_EN
  assign seq_target = bus.pred_valid ? bus.pred_pc : seq_pc;
`else
  assign seq_target = seq_pc;
`endif

  assign bus.fetch_pc = bus.pc_in;
  assign bus.halted   = (state == ST_HALT);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    bus.next_pc     = bus.pc_in;
    bus.fetch_valid = 1'b0;
    case (state)
      ST_BOOT: begin
        bus.next_pc = INIT_PC;
        cnt_nxt     = cnt - CNT_ONE;
        if (cnt <= CNT_ONE) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // Retracting fetch_valid is only legal on a redirect cycle.
          bus.next_pc = target;
          if (REDIRECT_BUBBLE != 0) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = BUBBLE_CNT;
          end
        end else begin
          bus.fetch_valid = 1'b1;
          if (bus.fetch_ready) begin
            bus.next_pc = seq_target;
            if (bus.halt_req) state_nxt = ST_HALT;
          end
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          bus.next_pc = target;
          cnt_nxt     = BUBBLE_CNT;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
          if (cnt <= CNT_ONE) state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (redirect) begin
          bus.next_pc = target;
          if (REDIRECT_BUBBLE != 0) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = BUBBLE_CNT;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (bus.wake) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BOOT;
      cnt   <= BOOT_CNT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a priority-rule reference model.
// A bench-side PC register closes the next_pc -> pc_in loop.
module tb_pc_sequencer;
  localparam logic [31:0] INIT = 32'hbfc00000;
  localparam int          BOOT = 2;
  localparam int          BUB  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_WIDTH(32)) ifc ();

  pc_sequencer #(
    .ADDR_WIDTH(32), .INIT_PC(INIT), .BOOT_CYCLES(BOOT), .REDIRECT_BUBBLE(BUB), .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always @(posedge clk) ifc.pc_in <= ifc.next_pc;

  int total = 0;
  int bad   = 0;

  // Reference model: remaining boot/bubble cycles, halt flag and its own copy of the PC.
  int          boot_left, stall_left, n_boot, n_stall;
  bit          sleeping, n_sleep;
  logic [31:0] mpc;
  logic        exp_fv, exp_halted;
  logic [31:0] exp_npc, exp_fpc;

  task automatic model_reset();
    boot_left = BOOT; stall_left = 0; sleeping = 0; mpc = INIT;
  endtask

  task automatic model_eval();
    logic [31:0] seq;
    n_boot = boot_left; n_stall = stall_left; n_sleep = sleeping;
    exp_halted = sleeping; exp_fpc = mpc; exp_fv = 1'b0; exp_npc = mpc;
    seq = mpc + 32'd4;
`ifdef PC_PREDICT_EN
    if (ifc.pred_valid) seq = ifc.pred_pc;
`endif
    if (boot_left > 0) begin
      exp_npc = INIT; n_boot = boot_left - 1;
    end else if (ifc.exc_valid || ifc.flush_valid) begin
      exp_npc = ifc.exc_valid ? ifc.exc_pc : ifc.flush_pc;
      n_stall = BUB; n_sleep = 0;
    end else if (stall_left > 0) begin
      n_stall = stall_left - 1;
    end else if (sleeping) begin
      if (ifc.wake) n_sleep = 0;
    end else begin
      exp_fv = 1'b1;
      if (ifc.fetch_ready) begin
        exp_npc = seq;
        if (ifc.halt_req) n_sleep = 1;
      end
    end
  endtask

  task automatic cyc_eval();
    @(negedge clk);
    model_eval();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    boot_left = n_boot; stall_left = n_stall; sleeping = n_sleep; mpc = exp_npc;
    #1;
  endtask

  task automatic drive(input logic rdy, input logic ev, input logic [31:0] ep,
                       input logic flv, input logic [31:0] fp, input logic h, input logic w);
    ifc.fetch_ready = rdy; ifc.exc_valid = ev; ifc.exc_pc = ep;
    ifc.flush_valid = flv; ifc.flush_pc = fp; ifc.halt_req = h; ifc.wake = w;
  endtask

  task automatic test_reset();
    logic        efv [5];
    logic [31:0] epc [5];
    efv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    epc = '{32'h0, 32'h0, 32'hbfc00000, 32'hbfc00004, 32'hbfc00008};
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ifc.fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b want=0", ifc.fetch_valid); end
    total++; if (ifc.halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", ifc.halted); end
    total++; if (ifc.next_pc !== INIT) begin bad++; $display("FAIL rst_npc got=%h want=%h", ifc.next_pc, INIT); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc_eval();
      total++; if (ifc.fetch_valid !== efv[i]) begin bad++; $display("FAIL boot_fv[%0d] got=%b want=%b", i, ifc.fetch_valid, efv[i]); end
      if (efv[i]) begin
        total++; if (ifc.fetch_pc !== epc[i]) begin bad++; $display("FAIL boot_fpc[%0d] got=%h want=%h", i, ifc.fetch_pc, epc[i]); end
      end
      total++; if (ifc.next_pc !== exp_npc) begin bad++; $display("FAIL boot_npc[%0d] got=%h want=%h", i, ifc.next_pc, exp_npc); end
      cyc_end();
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval();
    total++; if (ifc.fetch_pc !== 32'hbfc0000c) begin bad++; $display("FAIL stall_pre got=%h want=bfc0000c", ifc.fetch_pc); end
    cyc_end();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_eval();
      total++; if (ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'hbfc00010)
        begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h want=1/bfc00010", i, ifc.fetch_valid, ifc.fetch_pc); end
      total++; if (ifc.next_pc !== 32'hbfc00010) begin bad++; $display("FAIL stall_npc[%0d] got=%h want=bfc00010", i, ifc.next_pc); end
      cyc_end();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval(); cyc_end();
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'hbfc00014)
      begin bad++; $display("FAIL stall_adv got=%b/%h want=1/bfc00014", ifc.fetch_valid, ifc.fetch_pc); end
    cyc_end();
  endtask

  task automatic test_redirect();
    drive(1, 1, 32'hbfc00380, 1, 32'h80001000, 0, 0);
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b0) begin bad++; $display("FAIL redir_retract got=%b want=0", ifc.fetch_valid); end
    total++; if (ifc.next_pc !== 32'hbfc00380) begin bad++; $display("FAIL redir_prio got=%h want=bfc00380", ifc.next_pc); end
    cyc_end();
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b want=0", ifc.fetch_valid); end
    cyc_end();
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'hbfc00380)
      begin bad++; $display("FAIL redir_resume got=%b/%h want=1/bfc00380", ifc.fetch_valid, ifc.fetch_pc); end
    cyc_end();
  endtask

  task automatic test_halt();
    drive(1, 0, 0, 1, 32'h80000020, 0, 0);
    cyc_eval(); cyc_end();
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval(); cyc_end();
    drive(1, 0, 0, 0, 0, 1, 0);
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'h80000020)
      begin bad++; $display("FAIL halt_fire got=%b/%h want=1/80000020", ifc.fetch_valid, ifc.fetch_pc); end
    cyc_end();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc_eval();
      total++; if (ifc.halted !== 1'b1 || ifc.fetch_valid !== 1'b0)
        begin bad++; $display("FAIL halt_state[%0d] got=%b/%b want=1/0", i, ifc.halted, ifc.fetch_valid); end
      cyc_end();
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    cyc_eval(); cyc_end();
    drive(1, 0, 0, 0, 0, 1, 0);
    cyc_eval();
    total++; if (ifc.halted !== 1'b0 || ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'h80000024)
      begin bad++; $display("FAIL halt_wake got=%b/%b/%h want=0/1/80000024", ifc.halted, ifc.fetch_valid, ifc.fetch_pc); end
    cyc_end();
    drive(1, 1, 32'hbfc00380, 0, 0, 0, 1);
    cyc_eval();
    total++; if (ifc.halted !== 1'b1 || ifc.next_pc !== 32'hbfc00380)
      begin bad++; $display("FAIL halt_exc got=%b/%h want=1/bfc00380", ifc.halted, ifc.next_pc); end
    cyc_end();
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval(); cyc_end();
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'hbfc00380 || ifc.halted !== 1'b0)
      begin bad++; $display("FAIL halt_exc_resume got=%b/%h want=1/bfc00380", ifc.fetch_valid, ifc.fetch_pc); end
    cyc_end();
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 1, 32'hfffffffc, 0, 0);
    cyc_eval(); cyc_end();
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval(); cyc_end();
    cyc_eval();
    total++; if (ifc.next_pc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%h want=00000000", ifc.next_pc); end
    cyc_end();
    cyc_eval();
    total++; if (ifc.fetch_valid !== 1'b1 || ifc.fetch_pc !== 32'h0)
      begin bad++; $display("FAIL wrap_fpc got=%b/%h want=1/00000000", ifc.fetch_valid, ifc.fetch_pc); end
    cyc_end();
  endtask

  task automatic test_reset_in_flush();
    drive(1, 0, 0, 1, 32'h80000040, 0, 0);
    cyc_eval(); cyc_end();
    drive(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    total++; if (ifc.fetch_valid !== 1'b0 || ifc.next_pc !== INIT || ifc.halted !== 1'b0)
      begin bad++; $display("FAIL flush_rst got=%b/%h/%b want=0/%h/0", ifc.fetch_valid, ifc.next_pc, ifc.halted, INIT); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc_eval();
      total++; if (ifc.fetch_valid !== exp_fv) begin bad++; $display("FAIL reboot_fv[%0d] got=%b want=%b", i, ifc.fetch_valid, exp_fv); end
      if (i == 2) begin
        total++; if (ifc.fetch_pc !== INIT) begin bad++; $display("FAIL reboot_fpc got=%h want=%h", ifc.fetch_pc, INIT); end
      end
      cyc_end();
    end
  endtask

`ifdef PC_PREDICT_EN
  task automatic test_predict();
    drive(1, 0, 0, 0, 0, 0, 0);
    ifc.pred_valid = 1'b1; ifc.pred_pc = 32'h80000100;
    cyc_eval();
    total++; if (ifc.next_pc !== 32'h80000100) begin bad++; $display("FAIL pred_npc got=%h want=80000100", ifc.next_pc); end
    cyc_end();
    drive(1, 0, 0, 1, 32'h80002000, 0, 0);
    cyc_eval();
    total++; if (ifc.fetch_pc !== 32'h80000100) begin bad++; $display("FAIL pred_fpc got=%h want=80000100", ifc.fetch_pc); end
    total++; if (ifc.next_pc !== 32'h80002000) begin bad++; $display("FAIL pred_flush got=%h want=80002000", ifc.next_pc); end
    cyc_end();
    ifc.pred_valid = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    cyc_eval(); cyc_end();
  endtask
`endif

  task automatic test_random();
    logic [31:0] ep, fp;
    for (int i = 0; i < 3000; i++) begin
      ep = ($urandom_range(0, 9) == 0) ? 32'hfffffff8 : ($urandom() & 32'hfffffffc);
      fp = ($urandom_range(0, 9) == 0) ? 32'hfffffffc : ($urandom() & 32'hfffffffc);
      drive(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 99) < 4), ep,
            logic'($urandom_range(0, 99) < 5), fp,
            logic'($urandom_range(0, 99) < 6), logic'($urandom_range(0, 99) < 20));
`ifdef PC_PREDICT_EN
      ifc.pred_valid = logic'($urandom_range(0, 9) < 3);
      ifc.pred_pc    = $urandom() & 32'hfffffffc;
`endif
      cyc_eval();
      total++; if (ifc.fetch_valid !== exp_fv) begin bad++; $display("FAIL rnd_fv[%0d] got=%b want=%b", i, ifc.fetch_valid, exp_fv); end
      total++; if (ifc.halted !== exp_halted) begin bad++; $display("FAIL rnd_halted[%0d] got=%b want=%b", i, ifc.halted, exp_halted); end
      total++; if (ifc.next_pc !== exp_npc) begin bad++; $display("FAIL rnd_npc[%0d] got=%h want=%h", i, ifc.next_pc, exp_npc); end
      if (exp_fv) begin
        total++; if (ifc.fetch_pc !== exp_fpc) begin bad++; $display("FAIL rnd_fpc[%0d] got=%h want=%h", i, ifc.fetch_pc, exp_fpc); end
      end
      cyc_end();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef PC_PREDICT_EN
    ifc.pred_valid = 1'b0;
    ifc.pred_pc    = 32'h0;
`endif
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_in_flush();
`ifdef PC_PREDICT_EN
    test_predict();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
